xs3_serial_adder: RTL and testbench

//  Digit-serial adder for excess-3 (XS3) decimal operands, placed directly downstream of the BCD->XS3 code converter.

---
 rtl/xs3_serial_adder_if.sv | 28 ++
 rtl/xs3_serial_adder.sv | 137 +++++++++++++
 tb/tb_xs3_serial_adder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/xs3_serial_adder_if.sv
// Handshake bundle for the excess-3 digit-serial adder: digit-pair input side,
// sum-digit output side and the two sticky status flags.
interface xs3_serial_adder_if #(
    parameter int IDX_W = 3
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_a;
    logic [3:0]       in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_sum;
    logic             out_last;
    logic [IDX_W-1:0] out_idx;
    logic             ovf;
    logic             err;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_last, out_idx, ovf, err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_last, out_idx, ovf, err
    );
endinterface

// File: rtl/xs3_serial_adder.sv
// Digit-serial excess-3 adder, LSD first, one registered sum digit per transfer plus a final carry digit.
// Input code checking (sticky err) is built only when XS3_CODE_CHECK_EN is defined.
//
// state | meaning
// RUN   | accepting digit pairs
// CARRY | operand ended with carry out; emitting the extra XS3 '1' digit
module xs3_serial_adder #(
    parameter int MAX_DIGITS = 8,
    parameter int IDX_W      = 3
) (
    input  logic              clk,
    input  logic              rst,
    xs3_serial_adder_if.slave bus
);
    typedef enum logic {RUN = 1'b0, CARRY = 1'b1} state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_DIGITS - 1);

    state_e           state_q, state_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             out_valid_q, out_valid_d;
    logic [3:0]       out_sum_q, out_sum_d;
    logic             out_last_q, out_last_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             ovf_q, ovf_d;

    logic       reg_free;
    logic       in_xfer;
    logic       eff_last;
    logic [4:0] s;
    logic [3:0] s_digit;

    assign reg_free     = !out_valid_q || bus.out_ready;
    assign bus.in_ready = (state_q == RUN) && reg_free;
    assign in_xfer      = bus.in_valid && bus.in_ready;
    assign eff_last     = bus.in_last || (idx_q == LAST_IDX);

    // Binary sum of two XS3 digits carries a +6 bias; correct it back to +3.
    assign s       = {1'b0, bus.in_a} + {1'b0, bus.in_b} + {4'b0000, carry_q};
    assign s_digit = s[4] ? (s[3:0] + 4'd3) : (s[3:0] - 4'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= 4'b0000;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_last_q  <= out_last_d;
            out_idx_q   <= out_idx_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (in_xfer && eff_last && s[4]) state_d = CARRY;
            CARRY:   if (reg_free) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        carry_d     = carry_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_last_d  = out_last_q;
        out_idx_d   = out_idx_q;
        ovf_d       = ovf_q;
        if (bus.out_ready) out_valid_d = 1'b0;
        if (in_xfer) begin
            out_valid_d = 1'b1;
            out_sum_d   = s_digit;
            out_idx_d   = idx_q;
            ovf_d       = (ovf_q && (idx_q != '0)) || (eff_last && !bus.in_last);
            if (eff_last && !s[4]) begin
                out_last_d = 1'b1;
                carry_d    = 1'b0;
                idx_d      = '0;
            end else begin
                out_last_d = 1'b0;
                carry_d    = s[4];
                idx_d      = idx_q + 1'b1;
            end
        end else if (state_q == CARRY && reg_free) begin
            out_valid_d = 1'b1;
            out_sum_d   = 4'b0100;
            out_last_d  = 1'b1;
            out_idx_d   = idx_q;
            carry_d     = 1'b0;
            idx_d       = '0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.ovf       = ovf_q;

`ifdef XS3_CODE_CHECK_EN
    logic err_q, err_d;
    logic code_bad;

    assign code_bad = (bus.in_a < 4'd3) || (bus.in_a > 4'd12) ||
                      (bus.in_b < 4'd3) || (bus.in_b > 4'd12);

    always_comb begin
        err_d = err_q;
        if (in_xfer) begin
            if (code_bad)           err_d = 1'b1;
            else if (idx_q == '0)   err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_xs3_serial_adder.sv
// Randomized bench for xs3_serial_adder: decimal-arithmetic reference model feeding an output scoreboard.
`timescale 1ns/1ps
module tb_xs3_serial_adder;
    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       last;
    } in_t;

    typedef struct {
        logic [3:0] sum;
        logic       last;
        logic [2:0] idx;
        logic       ovf;
        logic       err;
        logic       cp;     // a carry digit follows this one
    } exp_t;

`ifdef XS3_CODE_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    xs3_serial_adder_if #(.IDX_W(3)) bus ();

    xs3_serial_adder #(.MAX_DIGITS(8), .IDX_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    in_t  inq[$];
    exp_t expq[$];
    bit   ready_pat[$];
    int   rdy_pct = 100;
    int   vld_pct = 100;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [3:0] sum, input logic last, input int idx,
                            input logic ovf, input logic err, input logic cp);
        exp_t e;
        e.sum  = sum;
        e.last = last;
        e.idx  = 3'(idx);
        e.ovf  = ovf;
        e.err  = err;
        e.cp   = cp;
        expq.push_back(e);
    endtask

    task automatic push_in(input logic [3:0] a, input logic [3:0] b, input logic last);
        in_t d;
        d.a    = a;
        d.b    = b;
        d.last = last;
        inq.push_back(d);
    endtask

    // Decimal operands, LSD first; mark_last=0 only makes sense for an 8-digit operand.
    task automatic add_operand(input int n, input int da[8], input int db[8], input bit mark_last);
        int c;
        int t;
        bit fin;
        c = 0;
        for (int i = 0; i < n; i++) begin
            fin = (i == n - 1);
            push_in(4'(da[i] + 3), 4'(db[i] + 3), fin && mark_last);
            t = da[i] + db[i] + c;
            c = t / 10;
            push_exp(4'(t % 10 + 3), fin && (c == 0), i, fin && !mark_last, 1'b0, fin && (c == 1));
        end
        if (c == 1) push_exp(4'd4, 1'b1, n, !mark_last, 1'b0, 1'b0);
    endtask

    task automatic cycle();
        exp_t e;
        bit   exp_ir;
        @(negedge clk);
        if (ready_pat.size() > 0) bus.out_ready = ready_pat.pop_front();
        else                      bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
        if (inq.size() > 0 && (bus.in_valid || $urandom_range(0, 99) < vld_pct)) begin
            bus.in_valid = 1'b1;
            bus.in_a     = inq[0].a;
            bus.in_b     = inq[0].b;
            bus.in_last  = inq[0].last;
        end else begin
            bus.in_valid = 1'b0;
            bus.in_a     = 4'($urandom_range(0, 15));
            bus.in_b     = 4'($urandom_range(0, 15));
            bus.in_last  = 1'($urandom_range(0, 1));
        end
        #1;
        exp_ir = 1'b1;
        if (bus.out_valid) begin
            if (expq.size() == 0) chk("spurious_out", 32'(bus.out_valid), 32'(0));
            else exp_ir = bus.out_ready && !expq[0].cp;
        end
        chk("in_ready", 32'(bus.in_ready), 32'(exp_ir));
        if (bus.out_valid && bus.out_ready && expq.size() > 0) begin
            e = expq.pop_front();
            chk("out_sum",  32'(bus.out_sum),  32'(e.sum));
            chk("out_last", 32'(bus.out_last), 32'(e.last));
            chk("out_idx",  32'(bus.out_idx),  32'(e.idx));
            chk("ovf",      32'(bus.ovf),      32'(e.ovf));
            chk("err",      32'(bus.err),      32'(e.err));
        end
        if (bus.in_valid && bus.in_ready) void'(inq.pop_front());
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && (inq.size() > 0 || expq.size() > 0); k++) cycle();
        chk("drain_exp", 32'(expq.size()), 32'(0));
        chk("drain_in",  32'(inq.size()),  32'(0));
    endtask

    // Asynchronous reset pulse landing between clock edges.
    task automatic do_reset();
        #2 rst = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_out_sum",   32'(bus.out_sum),   32'(0));
        chk("rst_out_last",  32'(bus.out_last),  32'(0));
        chk("rst_out_idx",   32'(bus.out_idx),   32'(0));
        chk("rst_ovf",       32'(bus.ovf),       32'(0));
        chk("rst_err",       32'(bus.err),       32'(0));
        chk("rst_in_ready",  32'(bus.in_ready),  32'(1));
        inq.delete();
        expq.delete();
        ready_pat.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int da[8];
        int db[8];
        int n;
        bit ml;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = 4'd0;
        bus.in_b      = 4'd0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) cycle();
        do_reset();

        // 47 + 85 = 132 with carry digit
        add_operand(2, '{7, 4, 0, 0, 0, 0, 0, 0}, '{5, 8, 0, 0, 0, 0, 0, 0}, 1'b1);
        drain();
        // 12 + 34 = 46, no carry digit
        add_operand(2, '{2, 1, 0, 0, 0, 0, 0, 0}, '{4, 3, 0, 0, 0, 0, 0, 0}, 1'b1);
        drain();
        // 47 + 85 again under a backpressure burst
        ready_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        add_operand(2, '{7, 4, 0, 0, 0, 0, 0, 0}, '{5, 8, 0, 0, 0, 0, 0, 0}, 1'b1);
        drain();
        // 99999999 + 1 without in_last: truncated at 8 digits, ovf set, then cleared
        add_operand(8, '{9, 9, 9, 9, 9, 9, 9, 9}, '{1, 0, 0, 0, 0, 0, 0, 0}, 1'b0);
        add_operand(1, '{3, 0, 0, 0, 0, 0, 0, 0}, '{4, 0, 0, 0, 0, 0, 0, 0}, 1'b1);
        drain();

        // reset while the carry digit is pending
        ready_pat = '{1'b0, 1'b0};
        add_operand(1, '{9, 0, 0, 0, 0, 0, 0, 0}, '{9, 0, 0, 0, 0, 0, 0, 0}, 1'b1);
        cycle();
        cycle();
        chk("carry_pending_valid", 32'(bus.out_valid), 32'(1));
        do_reset();
        add_operand(1, '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, 1'b1);
        drain();

        // invalid code 1111: s=1_0010 -> 0101 carry, then 0100; err only when checking is built
        push_in(4'b1111, 4'b0011, 1'b1);
        push_exp(4'b0101, 1'b0, 0, 1'b0, ERR_EN, 1'b1);
        push_exp(4'b0100, 1'b1, 1, 1'b0, ERR_EN, 1'b0);
        add_operand(1, '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, 1'b1);
        drain();

        for (int op = 0; op < 80; op++) begin
            if (op < 40) begin
                rdy_pct = 60;
                vld_pct = 70;
            end else begin
                rdy_pct = 100;
                vld_pct = 100;
            end
            n  = $urandom_range(1, 8);
            ml = (n < 8) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < 8; i++) begin
                da[i] = ($urandom_range(0, 3) == 0) ? 9 : $urandom_range(0, 9);
                db[i] = $urandom_range(0, 9);
            end
            add_operand(n, da, db, ml);
            if (op % 8 == 7) drain();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
